bin_sched_ctrl: RTL and testbench

Sequencer that drives one bin through the SAT engine.
- Loads the bin's clauses, var states and lvl states from bin memory into the engine arrays.
- Pulses the engine start, waits for done, latches the result, then writes clauses and states back to bin memory.
- Sits between the top-level bin scheduler and sat_engine. Memory data buses connect directly to the engine; this block only generates addresses, strobes and handshakes.

---
 rtl/bin_sched_ctrl_if.sv | 46 ++++
 rtl/bin_sched_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_bin_sched_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_sched_ctrl_if.sv
// Memory and engine side signals of bin_sched_ctrl; master = sequencer, slave = memory/engine.
// Memory beats complete on mem_ack_i (zero-wait allowed); engine handshake is start/done pulses.
interface bin_sched_ctrl_if #(
    parameter int NUM_CLAUSES  = 8,
    parameter int NUM_VARS     = 8,
    parameter int NUM_LVLS     = 8,
    parameter int WIDTH_BIN_ID = 10,
    parameter int WIDTH_LVL    = 16,
    parameter int WIDTH_IDX    = 3
);
    localparam int WIDTH_ADDR = WIDTH_BIN_ID + 2 + WIDTH_IDX;

    logic                    mem_rd_o;
    logic                    mem_wr_o;
    logic [WIDTH_ADDR-1:0]   mem_addr_o;
    logic                    mem_ack_i;

    logic [NUM_CLAUSES-1:0]  wr_carray_o;
    logic [NUM_CLAUSES-1:0]  rd_carray_o;
    logic [NUM_VARS-1:0]     wr_var_states_o;
    logic [NUM_LVLS-1:0]     wr_lvl_states_o;
    logic                    base_lvl_en_o;
    logic [WIDTH_LVL-1:0]    base_lvl_o;
    logic                    start_core_o;
    logic                    done_core_i;
    logic                    sat_i;
    logic                    unsat_i;
    logic [WIDTH_LVL-1:0]    bkt_lvl_i;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_i;

    modport master (
        output mem_rd_o, mem_wr_o, mem_addr_o,
        input  mem_ack_i,
        output wr_carray_o, rd_carray_o, wr_var_states_o, wr_lvl_states_o,
        output base_lvl_en_o, base_lvl_o, start_core_o,
        input  done_core_i, sat_i, unsat_i, bkt_lvl_i, bkt_bin_i
    );

    modport slave (
        input  mem_rd_o, mem_wr_o, mem_addr_o,
        output mem_ack_i,
        input  wr_carray_o, rd_carray_o, wr_var_states_o, wr_lvl_states_o,
        input  base_lvl_en_o, base_lvl_o, start_core_o,
        output done_core_i, sat_i, unsat_i, bkt_lvl_i, bkt_bin_i
    );
endinterface

// File: rtl/bin_sched_ctrl.sv
// Loads one bin into the SAT engine, runs it, writes it back; 2*(NUM_CLAUSES+2)+4 cycles min plus engine time.
// Each memory beat is held until mem_ack_i; BIN_SKIP_UNSAT_WB_EN drops write-back for unsat bins.
module bin_sched_ctrl #(
    parameter int NUM_CLAUSES  = 8,
    parameter int NUM_VARS     = 8,
    parameter int NUM_LVLS     = 8,
    parameter int WIDTH_BIN_ID = 10,
    parameter int WIDTH_LVL    = 16,
    parameter int WIDTH_IDX    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_bin_i,
    input  logic [WIDTH_BIN_ID-1:0] bin_id_i,
    input  logic [WIDTH_LVL-1:0]    base_lvl_i,
    output logic                    busy_o,
    output logic                    done_bin_o,
    output logic                    sat_o,
    output logic                    unsat_o,
    output logic [WIDTH_LVL-1:0]    bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0] bkt_bin_o,
    bin_sched_ctrl_if.master        bus
);
    typedef enum logic [3:0] {
        IDLE, LD_CLAUSE, LD_VARS, LD_LVLS, RUN,
        WAIT_CORE, UP_CLAUSE, UP_VARS, UP_LVLS, DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [WIDTH_IDX-1:0]    idx_q, idx_d;
    logic [WIDTH_BIN_ID-1:0] bin_id_q, bin_id_d;
    logic [WIDTH_LVL-1:0]    base_lvl_q, base_lvl_d;
    logic                    base_lvl_en_q, base_lvl_en_d;
    logic                    sat_q, sat_d;
    logic                    unsat_q, unsat_d;
    logic [WIDTH_LVL-1:0]    bkt_lvl_q, bkt_lvl_d;
    logic [WIDTH_BIN_ID-1:0] bkt_bin_q, bkt_bin_d;

    logic [1:0]              sel;
    logic                    mem_rd, mem_wr, start_core, done_bin;
    logic [NUM_CLAUSES-1:0]  wr_carray, rd_carray;
    logic [NUM_VARS-1:0]     wr_var;
    logic [NUM_LVLS-1:0]     wr_lvl;
    logic                    last_row;
    logic [NUM_CLAUSES-1:0]  row_onehot;

    assign last_row   = (idx_q == WIDTH_IDX'(NUM_CLAUSES - 1));
    assign row_onehot = NUM_CLAUSES'(1) << idx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            bin_id_q      <= '0;
            base_lvl_q    <= '0;
            base_lvl_en_q <= 1'b0;
            sat_q         <= 1'b0;
            unsat_q       <= 1'b0;
            bkt_lvl_q     <= '0;
            bkt_bin_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            bin_id_q      <= bin_id_d;
            base_lvl_q    <= base_lvl_d;
            base_lvl_en_q <= base_lvl_en_d;
            sat_q         <= sat_d;
            unsat_q       <= unsat_d;
            bkt_lvl_q     <= bkt_lvl_d;
            bkt_bin_q     <= bkt_bin_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        bin_id_d      = bin_id_q;
        base_lvl_d    = base_lvl_q;
        base_lvl_en_d = 1'b0;
        sat_d         = sat_q;
        unsat_d       = unsat_q;
        bkt_lvl_d     = bkt_lvl_q;
        bkt_bin_d     = bkt_bin_q;
        sel           = 2'd0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        wr_carray     = '0;
        rd_carray     = '0;
        wr_var        = '0;
        wr_lvl        = '0;
        start_core    = 1'b0;
        done_bin      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_bin_i) begin
                    bin_id_d      = bin_id_i;
                    base_lvl_d    = base_lvl_i;
                    base_lvl_en_d = 1'b1;
                    sat_d         = 1'b0;
                    unsat_d       = 1'b0;
                    idx_d         = '0;
                    state_d       = LD_CLAUSE;
                end
            end
            LD_CLAUSE: begin
                mem_rd    = 1'b1;
                // Engine row strobe only fires on the cycle the read data is valid.
                wr_carray = row_onehot & {NUM_CLAUSES{bus.mem_ack_i}};
                if (bus.mem_ack_i) begin
                    if (last_row) begin
                        idx_d   = '0;
                        state_d = LD_VARS;
                    end else begin
                        idx_d = idx_q + WIDTH_IDX'(1);
                    end
                end
            end
            LD_VARS: begin
                mem_rd = 1'b1;
                sel    = 2'd1;
                wr_var = {NUM_VARS{bus.mem_ack_i}};
                if (bus.mem_ack_i) state_d = LD_LVLS;
            end
            LD_LVLS: begin
                mem_rd = 1'b1;
                sel    = 2'd2;
                wr_lvl = {NUM_LVLS{bus.mem_ack_i}};
                if (bus.mem_ack_i) state_d = RUN;
            end
            RUN: begin
                start_core = 1'b1;
                state_d    = WAIT_CORE;
            end
            WAIT_CORE: begin
                if (bus.done_core_i) begin
                    sat_d     = bus.sat_i;
                    unsat_d   = bus.unsat_i;
                    bkt_lvl_d = bus.bkt_lvl_i;
                    bkt_bin_d = bus.bkt_bin_i;
`ifdef BIN_SKIP_UNSAT_WB_EN
                    state_d   = bus.unsat_i ? DONE : UP_CLAUSE;
`else
                    state_d   = UP_CLAUSE;
`endif
                end
            end
            UP_CLAUSE: begin
                mem_wr    = 1'b1;
                rd_carray = row_onehot;
                if (bus.mem_ack_i) begin
                    if (last_row) begin
                        idx_d   = '0;
                        state_d = UP_VARS;
                    end else begin
                        idx_d = idx_q + WIDTH_IDX'(1);
                    end
                end
            end
            UP_VARS: begin
                mem_wr = 1'b1;
                sel    = 2'd1;
                if (bus.mem_ack_i) state_d = UP_LVLS;
            end
            UP_LVLS: begin
                mem_wr = 1'b1;
                sel    = 2'd2;
                if (bus.mem_ack_i) state_d = DONE;
            end
            DONE: begin
                done_bin = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o     = (state_q != IDLE);
    assign done_bin_o = done_bin;
    assign sat_o      = sat_q;
    assign unsat_o    = unsat_q;
    assign bkt_lvl_o  = bkt_lvl_q;
    assign bkt_bin_o  = bkt_bin_q;

    assign bus.mem_rd_o        = mem_rd;
    assign bus.mem_wr_o        = mem_wr;
    assign bus.mem_addr_o      = (mem_rd | mem_wr) ? {bin_id_q, sel, idx_q} : '0;
    assign bus.wr_carray_o     = wr_carray;
    assign bus.rd_carray_o     = rd_carray;
    assign bus.wr_var_states_o = wr_var;
    assign bus.wr_lvl_states_o = wr_lvl;
    assign bus.base_lvl_en_o   = base_lvl_en_q;
    assign bus.base_lvl_o      = base_lvl_q;
    assign bus.start_core_o    = start_core;
endmodule

// File: tb/tb_bin_sched_ctrl.sv
// Self-checking bench for bin_sched_ctrl: vector table of bin runs, memory beats checked via a scoreboard.
module tb_bin_sched_ctrl;
    localparam int NC = 8;
`ifdef BIN_SKIP_UNSAT_WB_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    typedef struct {
        logic [9:0]  bin_id;
        logic [15:0] base_lvl;
        int          delay;
        int          lat;
        logic        sat;
        logic        unsat;
        logic [15:0] bkt_lvl;
        logic [9:0]  bkt_bin;
        logic        exp_sat;
        logic        exp_unsat;
        logic [15:0] exp_lvl;
        logic [9:0]  exp_bin;
        logic        exp_wb;
    } vec_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [14:0] addr;
        logic [7:0]  wc;
        logic [7:0]  rc;
        logic [7:0]  wv;
        logic [7:0]  wl;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        start_bin_i;
    logic [9:0]  bin_id_i;
    logic [15:0] base_lvl_i;
    logic        busy_o, done_bin_o, sat_o, unsat_o;
    logic [15:0] bkt_lvl_o;
    logic [9:0]  bkt_bin_o;

    bin_sched_ctrl_if #(.NUM_CLAUSES(8), .NUM_VARS(8), .NUM_LVLS(8),
                        .WIDTH_BIN_ID(10), .WIDTH_LVL(16), .WIDTH_IDX(3)) bus ();

    bin_sched_ctrl #(.NUM_CLAUSES(8), .NUM_VARS(8), .NUM_LVLS(8),
                     .WIDTH_BIN_ID(10), .WIDTH_LVL(16), .WIDTH_IDX(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_bin_i (start_bin_i),
        .bin_id_i    (bin_id_i),
        .base_lvl_i  (base_lvl_i),
        .busy_o      (busy_o),
        .done_bin_o  (done_bin_o),
        .sat_o       (sat_o),
        .unsat_o     (unsat_o),
        .bkt_lvl_o   (bkt_lvl_o),
        .bkt_bin_o   (bkt_bin_o),
        .bus         (bus)
    );

    int    total = 0;
    int    bad   = 0;
    int    cur_delay = 0;
    int    wr_beats  = 0;
    beat_t sb[$];
    vec_t  vecs[4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pk(input beat_t b);
        return {15'd0, b.rd, b.wr, b.addr, b.wc, b.rc, b.wv, b.wl};
    endfunction

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push_load(input logic [9:0] bin);
        for (int i = 0; i < NC; i++)
            sb.push_back('{1'b1, 1'b0, {bin, 2'd0, 3'(i)}, 8'(1 << i), 8'h00, 8'h00, 8'h00});
        sb.push_back('{1'b1, 1'b0, {bin, 2'd1, 3'd0}, 8'h00, 8'h00, 8'hFF, 8'h00});
        sb.push_back('{1'b1, 1'b0, {bin, 2'd2, 3'd0}, 8'h00, 8'h00, 8'h00, 8'hFF});
    endtask

    task automatic push_wb(input logic [9:0] bin);
        for (int i = 0; i < NC; i++)
            sb.push_back('{1'b0, 1'b1, {bin, 2'd0, 3'(i)}, 8'h00, 8'(1 << i), 8'h00, 8'h00});
        sb.push_back('{1'b0, 1'b1, {bin, 2'd1, 3'd0}, 8'h00, 8'h00, 8'h00, 8'h00});
        sb.push_back('{1'b0, 1'b1, {bin, 2'd2, 3'd0}, 8'h00, 8'h00, 8'h00, 8'h00});
    endtask

    // Memory responder and beat monitor: ack after cur_delay wait cycles, random ack noise when idle.
    initial begin
        int    wcnt;
        logic  req, ack, prev_pend;
        logic  [14:0] prev_addr;
        logic  [1:0]  prev_rw;
        beat_t got, exp_b;
        wcnt = 0;
        prev_pend = 1'b0;
        prev_addr = '0;
        prev_rw   = '0;
        bus.mem_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            req = bus.mem_rd_o | bus.mem_wr_o;
            if (req) begin
                if (wcnt >= cur_delay) begin
                    ack  = 1'b1;
                    wcnt = 0;
                end else begin
                    ack  = 1'b0;
                    wcnt++;
                end
            end else begin
                ack  = 1'($urandom_range(0, 1));
                wcnt = 0;
            end
            bus.mem_ack_i = ack;
            #1;
            if (!rst) begin
                prev_pend = 1'b0;
            end else begin
                chk("rd_wr_exclusive", {63'd0, bus.mem_rd_o & bus.mem_wr_o}, 64'd0);
                if (prev_pend) begin
                    chk("hold_addr", {49'd0, bus.mem_addr_o}, {49'd0, prev_addr});
                    chk("hold_req", {62'd0, bus.mem_rd_o, bus.mem_wr_o}, {62'd0, prev_rw});
                end
                got = '{bus.mem_rd_o, bus.mem_wr_o, bus.mem_addr_o, bus.wr_carray_o,
                        bus.rd_carray_o, bus.wr_var_states_o, bus.wr_lvl_states_o};
                if (req && ack) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", pk(got), 64'd0);
                    end else begin
                        exp_b = sb.pop_front();
                        chk("beat", pk(got), pk(exp_b));
                    end
                    if (bus.mem_wr_o) wr_beats++;
                end else begin
                    chk("no_strobe_wo_ack", {40'd0, got.wc, got.wv, got.wl}, 64'd0);
                end
                prev_pend = req & ~ack;
                prev_addr = bus.mem_addr_o;
                prev_rw   = {bus.mem_rd_o, bus.mem_wr_o};
            end
        end
    end

    task automatic run_bin(input vec_t v);
        int n;
        int m;
        cur_delay = v.delay;
        push_load(v.bin_id);
        if (v.exp_wb) push_wb(v.bin_id);
        cyc();
        wr_beats    = 0;
        start_bin_i = 1'b1;
        bin_id_i    = v.bin_id;
        base_lvl_i  = v.base_lvl;
        cyc();
        chk("base_lvl_en", {63'd0, bus.base_lvl_en_o}, 64'd1);
        chk("base_lvl", {48'd0, bus.base_lvl_o}, {48'd0, v.base_lvl});
        chk("busy_start", {63'd0, busy_o}, 64'd1);
        start_bin_i = 1'b0;
        bin_id_i    = ~v.bin_id;
        base_lvl_i  = ~v.base_lvl;
        n = 1;
        while (!bus.start_core_o && n < 500) begin
            cyc();
            n++;
        end
        chk("run_cycle", 64'(n), 64'(10 * (v.delay + 1) + 1));
        cyc();
        chk("start_core_pulse", {63'd0, bus.start_core_o}, 64'd0);
        chk("base_lvl_en_low", {63'd0, bus.base_lvl_en_o}, 64'd0);
        // A start request while the engine runs must be ignored.
        start_bin_i = 1'b1;
        repeat (v.lat - 1) cyc();
        bus.done_core_i = 1'b1;
        bus.sat_i       = v.sat;
        bus.unsat_i     = v.unsat;
        bus.bkt_lvl_i   = v.bkt_lvl;
        bus.bkt_bin_i   = v.bkt_bin;
        cyc();
        start_bin_i     = 1'b0;
        bus.done_core_i = 1'b0;
        bus.sat_i       = ~v.sat;
        bus.unsat_i     = ~v.unsat;
        bus.bkt_lvl_i   = ~v.bkt_lvl;
        bus.bkt_bin_i   = ~v.bkt_bin;
        m = 1;
        while (!done_bin_o && m < 500) begin
            cyc();
            m++;
        end
        chk("done_cycle", 64'(m), v.exp_wb ? 64'(10 * (v.delay + 1) + 1) : 64'd1);
        chk("busy_in_done", {63'd0, busy_o}, 64'd1);
        chk("sat", {63'd0, sat_o}, {63'd0, v.exp_sat});
        chk("unsat", {63'd0, unsat_o}, {63'd0, v.exp_unsat});
        chk("bkt_lvl", {48'd0, bkt_lvl_o}, {48'd0, v.exp_lvl});
        chk("bkt_bin", {54'd0, bkt_bin_o}, {54'd0, v.exp_bin});
        chk("wr_beats", 64'(wr_beats), v.exp_wb ? 64'd10 : 64'd0);
        cyc();
        chk("done_single_pulse", {63'd0, done_bin_o}, 64'd0);
        chk("busy_after_done", {63'd0, busy_o}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{10'd5,   16'h1234, 0, 1, 1'b1, 1'b0, 16'd3,    10'd2,   1'b1, 1'b0, 16'd3,    10'd2,   1'b1};
        vecs[1] = '{10'h2A7, 16'h00FF, 3, 4, 1'b0, 1'b1, 16'd7,    10'd9,   1'b0, 1'b1, 16'd7,    10'd9,   ~SKIP};
        vecs[2] = '{10'h155, 16'hA5A5, 1, 2, 1'b0, 1'b1, 16'h8001, 10'h200, 1'b0, 1'b1, 16'h8001, 10'h200, ~SKIP};
        vecs[3] = '{10'h3FF, 16'hFFFF, 2, 3, 1'b0, 1'b0, 16'hFFFF, 10'h3FF, 1'b0, 1'b0, 16'hFFFF, 10'h3FF, 1'b1};

        rst             = 1'b0;
        start_bin_i     = 1'b0;
        bin_id_i        = '0;
        base_lvl_i      = '0;
        bus.done_core_i = 1'b0;
        bus.sat_i       = 1'b0;
        bus.unsat_i     = 1'b0;
        bus.bkt_lvl_i   = '0;
        bus.bkt_bin_i   = '0;
        #12;
        chk("rst_busy_done", {62'd0, busy_o, done_bin_o}, 64'd0);
        chk("rst_result", {37'd0, sat_o, unsat_o, bkt_lvl_o, bkt_bin_o}, 64'd0);
        chk("rst_mem", {47'd0, bus.mem_rd_o, bus.mem_wr_o, bus.mem_addr_o}, 64'd0);
        chk("rst_engine", {46'd0, bus.start_core_o, bus.base_lvl_en_o, bus.rd_carray_o, bus.wr_carray_o}, 64'd0);
        @(negedge clk);
        #3 rst = 1'b1;

        for (int i = 0; i < 4; i++) run_bin(vecs[i]);

        // Engine done pulse while idle must not touch the latched result.
        cyc();
        bus.done_core_i = 1'b1;
        bus.sat_i       = 1'b1;
        bus.unsat_i     = 1'b1;
        bus.bkt_lvl_i   = 16'h0042;
        bus.bkt_bin_i   = 10'h011;
        cyc();
        bus.done_core_i = 1'b0;
        cyc();
        chk("idle_done_busy", {63'd0, busy_o}, 64'd0);
        chk("idle_done_result", {37'd0, sat_o, unsat_o, bkt_lvl_o, bkt_bin_o},
            {37'd0, vecs[3].exp_sat, vecs[3].exp_unsat, vecs[3].exp_lvl, vecs[3].exp_bin});

        // Reset in the middle of clause write-back (idx 4).
        cur_delay = 0;
        push_load(10'd9);
        push_wb(10'd9);
        cyc();
        start_bin_i = 1'b1;
        bin_id_i    = 10'd9;
        base_lvl_i  = 16'd1;
        cyc();
        start_bin_i = 1'b0;
        n = 1;
        while (!bus.start_core_o && n < 500) begin
            cyc();
            n++;
        end
        chk("rst_seq_run_cycle", 64'(n), 64'd11);
        cyc();
        bus.done_core_i = 1'b1;
        bus.sat_i       = 1'b1;
        bus.unsat_i     = 1'b0;
        bus.bkt_lvl_i   = 16'd5;
        bus.bkt_bin_i   = 10'd6;
        cyc();
        bus.done_core_i = 1'b0;
        repeat (4) cyc();
        chk("pre_rst_row4", {55'd0, bus.mem_wr_o, bus.rd_carray_o}, {55'd0, 1'b1, 8'h10});
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_ctrl", {60'd0, busy_o, done_bin_o, bus.mem_wr_o, bus.mem_rd_o}, 64'd0);
        chk("mid_rst_bus", {41'd0, bus.mem_addr_o, bus.rd_carray_o}, 64'd0);
        chk("mid_rst_result", {37'd0, sat_o, unsat_o, bkt_lvl_o, bkt_bin_o}, 64'd0);
        sb.delete();
        cyc();
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst_quiet", {62'd0, done_bin_o, busy_o}, 64'd0);
        end

        run_bin(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
